// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side byte streams plus the shared UART TX sink stream
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8
);
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         to_uart_data;
  logic                      to_uart_valid;
  logic                      to_uart_error;
  logic                      to_uart_ready;
  modport master (
    input  req_data, req_valid, req_last, to_uart_ready,
    output req_ready, to_uart_data, to_uart_valid, to_uart_error
  );
  modport slave (
    output req_data, req_valid, req_last, to_uart_ready,
    input  req_ready, to_uart_data, to_uart_valid, to_uart_error
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-level round-robin arbiter sharing one UART TX stream between requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  uart_tx_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_pulse
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d, last_grant_q, last_grant_d, winner;
  logic [TW-1:0] timer_q, timer_d;
  logic timeout_pulse_q, timeout_pulse_d;
  logic cur_valid, cur_last, accept;
  // Descending scan so the closest requester after last_grant is assigned last and wins
  always_comb begin
    logic [GW-1:0] idx;
    winner = last_grant_q;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
      winner = bus.req_valid[idx] ? idx : winner;
    end
  end
  assign cur_valid = bus.req_valid[grant_id_q];
  assign cur_last = bus.req_last[grant_id_q];
  assign busy = state_q == GRANT;
  assign accept = busy & cur_valid & bus.to_uart_ready;
  assign bus.to_uart_valid = busy & cur_valid;
  assign bus.to_uart_data = busy ? bus.req_data[grant_id_q*DATA_W +: DATA_W] : '0;
  assign bus.req_ready = busy ? NUM_REQ'(bus.to_uart_ready) << grant_id_q : '0;
  assign bus.to_uart_error = 1'b0;
  assign grant_id = grant_id_q;
  assign timeout_pulse = timeout_pulse_q;
  // A UART stall (valid high, ready low) neither clears nor advances the silence timer
  always_comb begin
    state_d = state_q;
    grant_id_d = grant_id_q;
    last_grant_d = last_grant_q;
    timer_d = timer_q;
    timeout_pulse_d = 1'b0;
    if (state_q == IDLE) begin
      if (|bus.req_valid) begin
        grant_id_d = winner;
        last_grant_d = winner;
        timer_d = '0;
        state_d = GRANT;
      end
    end else if (accept && cur_last) begin
      state_d = IDLE;
    end else if (accept) begin
      timer_d = '0;
    end else if (!cur_valid) begin
      if (TIMEOUT != 0 && timer_q == T_LAST) begin
        state_d = IDLE;
        timeout_pulse_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      grant_id_q <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      timer_q <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_id_q <= grant_id_d;
      last_grant_q <= last_grant_d;
      timer_q <= timer_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end
endmodule
